// File: rtl/rv_alu_arb.sv
// Two-requester front end sharing one combinational ALU through a single result slot.
// Round-robin grant; the slot refills in the same cycle it drains, so throughput is one op per cycle.

module rv_alu #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  input  logic [3:0]    i_op,
  output logic [DW-1:0] o_result,
  output logic          o_zero,
  output logic          o_err
);
  always_comb begin
    o_result = '0;
    o_err    = 1'b0;
    case (i_op)
      4'b0000: o_result = i_a & i_b;
      4'b0001: o_result = i_a | i_b;
      4'b0010: o_result = i_a + i_b;
      4'b0110: o_result = i_a - i_b;
      4'b0111: o_result = {{(DW-1){1'b0}}, (i_a < i_b)};
      4'b1100: o_result = ~(i_a | i_b);
      default: o_err    = 1'b1;
    endcase
    // Illegal ops report zero data but not the zero flag.
    o_zero = ~o_err & (o_result == '0);
  end
endmodule

// Handshake: a request is accepted on a cycle where reqN_valid and reqN_ready are both high;
// a response completes on a cycle where rspN_valid and rspN_ready are both high. Ready is a
// combinational function of valid and slot occupancy; valid never depends on ready.
module rv_alu_arb #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  input  logic          req1_valid,
  output logic          req0_ready,
  output logic          req1_ready,
  input  logic [DW-1:0] req0_in1,
  input  logic [DW-1:0] req0_in2,
  input  logic [DW-1:0] req1_in1,
  input  logic [DW-1:0] req1_in2,
  input  logic [3:0]    req0_op,
  input  logic [3:0]    req1_op,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  input  logic          rsp0_ready,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zflag,
  output logic          rsp_err,
  output logic          o_dbg_state
);
  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_owner;
  logic [DW-1:0]   r_data;
  logic            r_zflag;
  logic            r_err;
  logic            r_prio;

  logic            w_fire;
  logic            w_slot_free;
  logic            w_any_req;
  logic            w_grant;
  logic            w_accept;
  logic [DW-1:0]   w_a, w_b;
  logic [3:0]      w_op;
  logic [DW-1:0]   w_result;
  logic            w_zero;
  logic            w_err;

  assign w_a  = w_grant ? req1_in1 : req0_in1;
  assign w_b  = w_grant ? req1_in2 : req0_in2;
  assign w_op = w_grant ? req1_op  : req0_op;

  rv_alu #(.DW(DW)) u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_op     (w_op),
    .o_result (w_result),
    .o_zero   (w_zero),
    .o_err    (w_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_owner <= 1'b0;
      r_data  <= '0;
      r_zflag <= 1'b0;
      r_err   <= 1'b0;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner <= w_grant;
        r_data  <= w_result;
        r_zflag <= w_zero;
        r_err   <= w_err;
        r_prio  <= ~w_grant;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_slot_free = 1'b0;
    w_any_req   = req0_valid | req1_valid;
    // With both requesting, prio picks; otherwise the lone requester wins.
    w_grant     = (req0_valid & req1_valid) ? r_prio : req1_valid;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    w_accept    = 1'b0;

    case (r_state)
      S_EMPTY: w_slot_free = 1'b1;
      S_FULL: begin
        w_fire      = r_owner ? rsp1_ready : rsp0_ready;
        w_slot_free = w_fire;
      end
      default: w_slot_free = 1'b0;
    endcase

    if (!rst && w_slot_free && w_any_req) begin
      req0_ready = ~w_grant;
      req1_ready = w_grant;
      w_accept   = 1'b1;
    end

    if (w_accept)    w_state_nxt = S_FULL;
    else if (w_fire) w_state_nxt = S_EMPTY;
  end

  always_comb begin
    rsp0_valid  = (r_state == S_FULL) & ~r_owner;
    rsp1_valid  = (r_state == S_FULL) &  r_owner;
    rsp_data    = (r_state == S_FULL) ? r_data : '0;
    rsp_zflag   = (r_state == S_FULL) & r_zflag;
    rsp_err     = (r_state == S_FULL) & r_err;
    o_dbg_state = r_state;
  end
endmodule

// File: tb/tb_rv_alu_arb.sv
// Directed bench for rv_alu_arb: hand-computed vectors, one checking task, one summary line.
`timescale 1ns/1ps
module tb_rv_alu_arb;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic [3:0]    req0_op, req1_op;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready, rsp1_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_zflag, rsp_err;
  logic          o_dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  rv_alu_arb #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req1_valid  (req1_valid),
    .req0_ready  (req0_ready),
    .req1_ready  (req1_ready),
    .req0_in1    (req0_in1),
    .req0_in2    (req0_in2),
    .req1_in1    (req1_in1),
    .req1_in2    (req1_in2),
    .req0_op     (req0_op),
    .req1_op     (req1_op),
    .rsp0_valid  (rsp0_valid),
    .rsp1_valid  (rsp1_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp1_ready  (rsp1_ready),
    .rsp_data    (rsp_data),
    .rsp_zflag   (rsp_zflag),
    .rsp_err     (rsp_err),
    .o_dbg_state (o_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req0(input logic v, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req0_valid = v; req0_op = op; req0_in1 = a; req0_in2 = b;
  endtask

  task automatic drive_req1(input logic v, input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req1_valid = v; req1_op = op; req1_in1 = a; req1_in2 = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive_req0(1'b1, 4'b0010, 32'd1, 32'd1);
    drive_req1(1'b0, 4'b0000, 32'd0, 32'd0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // Reset: no accept while rst is high, all outputs clear after release.
    step(); step();
    #1;
    check("rst_no_ready0", 32'(req0_ready), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_rsp0v", 32'(rsp0_valid), 32'd0);
    check("post_rst_rsp1v", 32'(rsp1_valid), 32'd0);
    check("post_rst_data", rsp_data, 32'd0);
    check("post_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check("post_rst_flags", {30'd0, rsp_zflag, rsp_err}, 32'd0);

    // ADD 5+3 with latency 1.
    step();
    drive_req0(1'b1, 4'b0010, 32'd5, 32'd3);
    #1;
    check("add_req0_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    #1;
    check("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("add_data", rsp_data, 32'd8);
    check("add_flags", {30'd0, rsp_zflag, rsp_err}, 32'd0);
    step();
    #1;
    check("add_drained_state", 32'(o_dbg_state), 32'd0);
    check("add_drained_data", rsp_data, 32'd0);

    // Both valid after reset: req0 SUB 7-7 first, then req1 SLT 3<9.
    do_reset();
    drive_req0(1'b1, 4'b0110, 32'd7, 32'd7);
    drive_req1(1'b1, 4'b0111, 32'd3, 32'd9);
    #1;
    check("contend_r0_ready", 32'(req0_ready), 32'd1);
    check("contend_r1_ready", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    #1;
    check("sub_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("sub_data", rsp_data, 32'd0);
    check("sub_zflag", 32'(rsp_zflag), 32'd1);
    check("slt_r1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    #1;
    check("slt_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("slt_data", rsp_data, 32'd1);
    check("slt_zflag", 32'(rsp_zflag), 32'd0);
    step();

    // Backpressure: req0 result held while req1 waits.
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drive_req0(1'b1, 4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    #1;
    check("and_r0_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    drive_req1(1'b1, 4'b0001, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_r1_ready", 32'(req1_ready), 32'd0);
      check("hold_rsp0_valid", 32'(rsp0_valid), 32'd1);
      check("hold_data", rsp_data, 32'h0000_F000);
      step();
    end
    rsp0_ready = 1'b1;
    #1;
    check("release_r1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b0;
    #1;
    check("or_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("or_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("or_data", rsp_data, 32'd3);
    step();
    #1;
    check("nonowner_ready_ignored", 32'(rsp1_valid), 32'd1);
    rsp1_ready = 1'b1;
    step();

    // Illegal op from req1.
    drive_req1(1'b1, 4'b1111, 32'd5, 32'd6);
    #1;
    check("ill_r1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    #1;
    check("ill_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("ill_err", 32'(rsp_err), 32'd1);
    check("ill_data", rsp_data, 32'd0);
    check("ill_zflag", 32'(rsp_zflag), 32'd0);
    step();

    // Continuous contention: grants alternate starting with req0 (last winner was req1).
    drive_req0(1'b1, 4'b1100, 32'd0, 32'd0);
    drive_req1(1'b1, 4'b0010, 32'd1, 32'd2);
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rr_r0_ready", 32'(req0_ready), 32'((i % 2) == 0));
      check("rr_r1_ready", 32'(req1_ready), 32'((i % 2) == 1));
      if (i > 0) begin
        check("rr_data", rsp_data, exp_q.pop_front());
        check("rr_zflag", 32'(rsp_zflag), 32'd0);
      end
      exp_q.push_back(((i % 2) == 0) ? 32'hFFFF_FFFF : 32'd3);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("rr_last_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("rr_last_data", rsp_data, exp_q.pop_front());
    step();

    // Reset while FULL discards the result and restores prio to req0.
    rsp0_ready = 1'b0;
    drive_req0(1'b1, 4'b0010, 32'd2, 32'd2);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("rst_full_rsp0v", 32'(rsp0_valid), 32'd1);
    check("rst_blocks_r1", 32'(req1_ready), 32'd0);
    step();
    rst = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("rst_full_rsp0v_after", 32'(rsp0_valid), 32'd0);
    check("rst_full_rsp1v_after", 32'(rsp1_valid), 32'd0);
    check("rst_full_data", rsp_data, 32'd0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_prio_r0_ready", 32'(req0_ready), 32'd1);
    check("rst_prio_r1_ready", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    #1;
    check("final_data", rsp_data, 32'd4);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
